// File: rtl/seg7_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_pkg : segment patterns, nibble decode and digit-index width helper
// Revision : 1.0
// ----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [0:6] seg_t;   // index 0 = segment a, active-low

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t seg7_lookup(input logic [3:0] nibble, input logic hex_mode);
        seg_t pat;
        pat = SEG_BLANK;
        case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            4'hF: pat = SEG_F;
        endcase
        // Non-decimal codes are only legible in hex mode
        if (!hex_mode && nibble > 4'd9) begin
            pat = SEG_BLANK;
        end
        return pat;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode : combinational nibble to active-low abcdefg pattern
// Revision    : 1.0
// ----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output seg_t       o_seg
);

    assign o_seg = seg7_lookup(i_nibble, i_hex_mode);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_scan_driver : time-multiplexed N-digit 7-segment driver with
//                    frame-atomic update, zero blanking, blink and dead-time
// Revision         : 1.0
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic                  hex_mode,
    input  logic                  lzb_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [0:6]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int IDX_W = int'(idx_width(N_DIGITS));
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES <= 1) ? 1 : $clog2(BLINK_FRAMES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*N_DIGITS-1:0] active_q, active_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    seg_t                  seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [3:0]            w_nib;
    logic                  w_upper_zero;
    logic                  w_lz_blank;
    logic                  w_blink_sel;
    seg_t                  w_dec_seg;

    always_comb begin
        w_slot_end    = (cnt_q == CNT_LAST);
        w_frame_end   = w_slot_end && (idx_q == IDX_LAST);
        cnt_d         = w_slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        if (w_slot_end) begin
            idx_d = w_frame_end ? '0 : idx_q + IDX_W'(1);
        end
        // A load on the boundary edge bypasses shadow straight into active
        shadow_d      = load ? data : shadow_q;
        active_d      = w_frame_end ? shadow_d : active_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (w_frame_end) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
        frame_tick_d  = w_frame_end;
    end

    // Walk from the most significant digit so zero-run detection is cumulative
    always_comb begin
        w_nib        = '0;
        w_upper_zero = 1'b1;
        w_lz_blank   = 1'b0;
        w_blink_sel  = 1'b0;
        an_d         = '1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (active_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                w_nib       = active_q[4*i +: 4];
                w_lz_blank  = w_upper_zero && (i != 0);
                w_blink_sel = blink_mask[i];
            end
            an_d[i] = !((cnt_q != '0) && (idx_q == IDX_W'(i)));
        end
    end

    seg7_decode u_decode (
        .i_nibble   (w_nib),
        .i_hex_mode (hex_mode),
        .o_seg      (w_dec_seg)
    );

    always_comb begin
        seg_d = w_dec_seg;
        if ((cnt_q == '0) || (lzb_en && w_lz_blank) || (blink_phase_q && w_blink_sel)) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
